// File: rtl/risc_spm_pkg.sv
// Shared RISC-SPM datapath constants: address width, address type and return-stack depth.
package risc_spm_pkg;

  localparam int unsigned WORD_SIZE = 8;
  localparam int unsigned RAS_DEPTH = 4;

  typedef logic [WORD_SIZE-1:0] addr_t;

endpackage

// File: rtl/ras_mem.sv
// Return-stack storage: depth x word_size register file, one write port, one async read port, no reset.
module ras_mem
  import risc_spm_pkg::*;
#(
  parameter int unsigned word_size = WORD_SIZE,
  parameter int unsigned depth     = RAS_DEPTH,
  parameter int unsigned aw        = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [aw-1:0]        waddr_i,
  input  logic [word_size-1:0] wdata_i,
  input  logic [aw-1:0]        raddr_i,
  output logic [word_size-1:0] rdata_o
);

  logic [word_size-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_addr_stack.sv
// LIFO of subroutine return addresses feeding the PC load path.
// Build option RAS_WRAP_EN: circular stack, a push while full overwrites the oldest entry.
module return_addr_stack
  import risc_spm_pkg::*;
#(
  parameter int unsigned word_size = WORD_SIZE,
  parameter int unsigned depth     = RAS_DEPTH,
  parameter int unsigned ptr_w     = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [word_size-1:0] push_addr,
  input  logic                 pop,
  output logic [word_size-1:0] pop_addr,
  output logic                 load_pc,
  output logic                 full,
  output logic                 empty,
  output logic [ptr_w:0]       count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 err_clr
);

  localparam int unsigned CW = ptr_w + 1;

  // Pointer arithmetic modulo depth, valid for non-power-of-two depths too.
  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  function automatic logic [ptr_w-1:0] ptr_dec(input logic [ptr_w-1:0] p);
    return (p == '0) ? ptr_w'(depth - 1) : p - ptr_w'(1);
  endfunction

  logic [ptr_w-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [word_size-1:0] pop_addr_q, pop_addr_d;
  logic                 load_pc_q, load_pc_d;
  logic                 full_q, empty_q;
  logic                 ovf_q, ovf_d, udf_q, udf_d;
  logic                 ovf_set, udf_set;

  logic                 mem_we;
  logic [ptr_w-1:0]     mem_waddr, top_idx;
  logic [word_size-1:0] mem_rdata;

  assign top_idx = ptr_dec(wr_ptr_q);

  ras_mem #(
    .word_size (word_size),
    .depth     (depth),
    .aw        (ptr_w)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (push_addr),
    .raddr_i (top_idx),
    .rdata_o (mem_rdata)
  );

  // wr_ptr_q is the next free slot; the top of stack sits one below it.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pop_addr_d = pop_addr_q;
    load_pc_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;

    if (push && pop) begin
      load_pc_d = 1'b1;
      if (empty_q) begin
        pop_addr_d = push_addr;
      end else begin
        pop_addr_d = mem_rdata;
        mem_we     = 1'b1;
        mem_waddr  = top_idx;
      end
    end else if (pop) begin
      if (empty_q) begin
        udf_set = 1'b1;
      end else begin
        pop_addr_d = mem_rdata;
        load_pc_d  = 1'b1;
        wr_ptr_d   = top_idx;
        count_d    = count_q - CW'(1);
      end
    end else if (push) begin
      if (!full_q) begin
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
        count_d  = count_q + CW'(1);
      end else begin
`ifdef RAS_WRAP_EN
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
`else
        ovf_set  = 1'b1;
`endif
      end
    end

    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (ovf_set) ovf_d = 1'b1;
      if (udf_set) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pop_addr_q <= '0;
      load_pc_q  <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pop_addr_q <= pop_addr_d;
      load_pc_q  <= load_pc_d;
      full_q     <= (count_d == CW'(depth));
      empty_q    <= (count_d == '0);
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign pop_addr  = pop_addr_q;
  assign load_pc   = load_pc_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed vector bench for return_addr_stack; honours RAS_WRAP_EN for the overfill expectations.
module tb_return_addr_stack;
  import risc_spm_pkg::*;

`ifdef RAS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       push, pop, err_clr;
  addr_t      push_addr;
  addr_t      pop_addr;
  logic       load_pc, full, empty, overflow, underflow;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  return_addr_stack dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .pop_addr  (pop_addr),
    .load_pc   (load_pc),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .err_clr   (err_clr)
  );

  typedef struct {
    logic       push;
    logic [7:0] addr;
    logic       pop;
    logic       clr;
    logic [7:0] e_pa;
    logic       e_lp;
    logic [2:0] e_cnt;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic       e_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic pu, input logic [7:0] a, input logic po, input logic cl,
                              input logic [7:0] pa, input logic lp, input logic [2:0] c,
                              input logic em, input logic fu, input logic ov, input logic ud);
    vec_t v;
    v.push = pu; v.addr = a; v.pop = po; v.clr = cl;
    v.e_pa = pa; v.e_lp = lp; v.e_cnt = c; v.e_empty = em; v.e_full = fu;
    v.e_ovf = ov; v.e_udf = ud;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " pop_addr"},  int'(pop_addr),  int'(v.e_pa));
    check({tag, " load_pc"},   int'(load_pc),   int'(v.e_lp));
    check({tag, " count"},     int'(count),     int'(v.e_cnt));
    check({tag, " empty"},     int'(empty),     int'(v.e_empty));
    check({tag, " full"},      int'(full),      int'(v.e_full));
    check({tag, " overflow"},  int'(overflow),  int'(v.e_ovf));
    check({tag, " underflow"}, int'(underflow), int'(v.e_udf));
  endtask

  task automatic drive(input logic pu, input logic [7:0] a, input logic po, input logic cl);
    @(negedge clk);
    push = pu; push_addr = a; pop = po; err_clr = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [7:0] p0, p1, p2, p3;

    // {push, addr, pop, clr} -> {pop_addr, load_pc, count, empty, full, ovf, udf}
    // LIFO order
    vecs.push_back(mk(1, 8'h10, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h20, 0, 0, 8'h00, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h30, 0, 0, 8'h00, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h30, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h20, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h10, 1, 0, 1, 0, 0, 0));
    // underflow, hold, clear
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h10, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h10, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 8'h10, 0, 0, 1, 0, 0, 0));
    // fill and overfill
    vecs.push_back(mk(1, 8'h01, 0, 0, 8'h10, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h02, 0, 0, 8'h10, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h03, 0, 0, 8'h10, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h04, 0, 0, 8'h10, 0, 4, 0, 1, 0, 0));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h10, 0, 4, 0, 1, !WRAP, 0));
    p0 = WRAP ? 8'h05 : 8'h04;
    p1 = WRAP ? 8'h04 : 8'h03;
    p2 = WRAP ? 8'h03 : 8'h02;
    p3 = WRAP ? 8'h02 : 8'h01;
    vecs.push_back(mk(0, 8'h00, 1, 0, p0, 1, 3, 0, 0, !WRAP, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, p1, 1, 2, 0, 0, !WRAP, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, p2, 1, 1, 0, 0, !WRAP, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, p3, 1, 0, 1, 0, !WRAP, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, p3, 0, 0, 1, 0, 0, 0));
    // simultaneous push/pop with entries
    vecs.push_back(mk(1, 8'hA0, 0, 0, p3, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA1, 0, 0, p3, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'hB0, 1, 0, 8'hA1, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'hB0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'hA0, 1, 0, 1, 0, 0, 0));
    // empty bypass, then clear winning over a fresh underflow
    vecs.push_back(mk(1, 8'h7F, 1, 0, 8'h7F, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h7F, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h7F, 0, 0, 1, 0, 0, 0));

    rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_addr = '0;
    #12;
    check_all("reset", mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.push, v.addr, v.pop, v.clr);
      check_all($sformatf("vec%0d", i), v);
    end

    // asynchronous reset between edges while load_pc is high
    drive(1, 8'h31, 0, 0);
    drive(1, 8'h32, 0, 0);
    drive(1, 8'h33, 0, 0);
    drive(1, 8'h34, 0, 0);
    drive(0, 8'h00, 1, 0);
    check("pre-rst load_pc", int'(load_pc), 1);
    check("pre-rst pop_addr", int'(pop_addr), 32'h34);
    check("pre-rst count", int'(count), 3);
    #2;
    rst = 1'b1;
    #1;
    check("async-rst load_pc", int'(load_pc), 0);
    check("async-rst count", int'(count), 0);
    check("async-rst empty", int'(empty), 1);
    check("async-rst pop_addr", int'(pop_addr), 0);
    @(negedge clk);
    rst = 1'b0; pop = 1'b0;
    // entries were discarded: a pop now underflows without a pulse
    drive(0, 8'h00, 1, 0);
    check("post-rst pop load_pc", int'(load_pc), 0);
    check("post-rst pop underflow", int'(underflow), 1);
    check("post-rst pop_addr", int'(pop_addr), 0);
    drive(0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
